cmerge4_arb_mmu: RTL and testbench

- Clocked four-to-one merge stage; the converging counterpart of the one-to-four drive/free selector used in the MMU control path.
- Four upstream requesters each issue a single-cycle drive pulse with a data word. The block arbitrates among them round-robin.
- Forwards one transaction at a time to a single downstream drive/free pair, and returns a free pulse to the requester that won.
- Sits where MMU request streams (e.g. ITLB miss, DTLB miss, prefetch, flush) converge on the shared page-table walker.

---
 rtl/cmerge4_arb_mmu.sv | 157 +++++++++++++++
 tb/tb_cmerge4_arb_mmu.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmerge4_arb_mmu.sv
// cmerge4_arb_mmu: merges four single-cycle drive requests onto one downstream drive/free pair; round-robin grant, or fixed priority (port 0 highest) with CMERGE_FIXED_PRIO_EN.
// Latency: i_driveN -> o_driveNext 2 cycles when idle; i_freeNext -> o_freeN 1 cycle; next grant earliest 2 cycles after i_freeNext.
// Backpressure: one transaction in flight; other requests wait in pend until i_freeNext; a re-drive on a still-pending port is dropped and sets o_overflow.
module cmerge4_arb_mmu #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_drive0,
    input  logic                  i_drive1,
    input  logic                  i_drive2,
    input  logic                  i_drive3,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    input  logic [DATA_WIDTH-1:0] i_data2,
    input  logic [DATA_WIDTH-1:0] i_data3,
    output logic                  o_free0,
    output logic                  o_free1,
    output logic                  o_free2,
    output logic                  o_free3,
    output logic                  o_driveNext,
    output logic [DATA_WIDTH-1:0] o_dataNext,
    output logic [NUM_PORTS-1:0]  o_select,
    input  logic                  i_freeNext,
    output logic                  o_overflow
);
    localparam int IDX_W = $clog2(NUM_PORTS);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                stateQ, stateD;
    logic [NUM_PORTS-1:0]  driveVec, pendQ, pendD, pendKept, clrMask;
    logic [NUM_PORTS-1:0]  freeQ, freeD, selectD;
    logic [DATA_WIDTH-1:0] dataIn [NUM_PORTS];
    logic [DATA_WIDTH-1:0] dataQ  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] dataNextD;
    logic [IDX_W-1:0]      scanBase, cand, grantIdx, gQ, gD;
    logic                  grantVld, driveNextD, overflowD;

    assign driveVec  = {i_drive3, i_drive2, i_drive1, i_drive0};
    assign dataIn[0] = i_data0;
    assign dataIn[1] = i_data1;
    assign dataIn[2] = i_data2;
    assign dataIn[3] = i_data3;
    assign {o_free3, o_free2, o_free1, o_free0} = freeQ;

`ifdef CMERGE_FIXED_PRIO_EN
    assign scanBase = '0;
`else
    logic [IDX_W-1:0] rrPtr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr <= '0;
        end else if (stateQ == WAIT && i_freeNext) begin
            rrPtr <= gQ + IDX_W'(1);
        end
    end

    assign scanBase = rrPtr;
`endif

    // Descending scan so the candidate closest to scanBase is the one left standing.
    always_comb begin
        grantVld = 1'b0;
        grantIdx = '0;
        cand     = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand = scanBase + i[IDX_W-1:0];
            if (pendQ[cand]) begin
                grantVld = 1'b1;
                grantIdx = cand;
            end
        end
    end

    // Completion clears before capture, so a same-cycle re-drive of the freed port is legal.
    always_comb begin
        clrMask = '0;
        if (stateQ == WAIT && i_freeNext) begin
            clrMask[gQ] = 1'b1;
        end
        pendKept  = pendQ & ~clrMask;
        pendD     = pendKept;
        overflowD = o_overflow;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (driveVec[i]) begin
                if (pendKept[i]) begin
                    overflowD = 1'b1;
                end else begin
                    pendD[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stateD     = stateQ;
        driveNextD = 1'b0;
        dataNextD  = o_dataNext;
        selectD    = o_select;
        freeD      = '0;
        gD         = gQ;
        case (stateQ)
            IDLE: begin
                if (grantVld) begin
                    stateD     = WAIT;
                    driveNextD = 1'b1;
                    dataNextD  = dataQ[grantIdx];
                    selectD    = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grantIdx;
                    gD         = grantIdx;
                end else begin
                    selectD = '0;
                end
            end
            WAIT: begin
                if (i_freeNext) begin
                    stateD    = IDLE;
                    freeD[gQ] = 1'b1;
                    selectD   = '0;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ      <= IDLE;
            pendQ       <= '0;
            gQ          <= '0;
            freeQ       <= '0;
            o_driveNext <= 1'b0;
            o_dataNext  <= '0;
            o_select    <= '0;
            o_overflow  <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                dataQ[i] <= '0;
            end
        end else begin
            stateQ      <= stateD;
            pendQ       <= pendD;
            gQ          <= gD;
            freeQ       <= freeD;
            o_driveNext <= driveNextD;
            o_dataNext  <= dataNextD;
            o_select    <= selectD;
            o_overflow  <= overflowD;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (driveVec[i] && !pendKept[i]) begin
                    dataQ[i] <= dataIn[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_cmerge4_arb_mmu.sv
// Bench for cmerge4_arb_mmu: grants are checked against an expected-order queue filled as requests are driven;
// free pulses and select hold are checked every cycle against the outstanding grant.
`timescale 1ns/1ps
module tb_cmerge4_arb_mmu;
    localparam int DW = 32;

    typedef struct {
        logic [1:0]    port;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    drv = '0;
    logic [DW-1:0] dat [4];
    logic          freeNext = 1'b0;
    wire  [3:0]    freeV;
    wire           driveNext;
    wire  [DW-1:0] dataNext;
    wire  [3:0]    sel;
    wire           overflow;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t grantQ[$];
    logic outstanding = 1'b0;
    logic [3:0] grantMask = '0;
    int   cd = 0;
    int   autoDelay = 0;
    int   drvSeen = 0;
    int   freeSeen = 0;

    always #5 clk = ~clk;

    cmerge4_arb_mmu #(.NUM_PORTS(4), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_drive0(drv[0]), .i_drive1(drv[1]), .i_drive2(drv[2]), .i_drive3(drv[3]),
        .i_data0(dat[0]), .i_data1(dat[1]), .i_data2(dat[2]), .i_data3(dat[3]),
        .o_free0(freeV[0]), .o_free1(freeV[1]), .o_free2(freeV[2]), .o_free3(freeV[3]),
        .o_driveNext(driveNext), .o_dataNext(dataNext), .o_select(sel),
        .i_freeNext(freeNext), .o_overflow(overflow)
    );

    task automatic expectGrant(input logic [1:0] p, input logic [DW-1:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        grantQ.push_back(e);
    endtask

    // One clock: retire single-cycle inputs, then check free, grant and select against the scoreboard.
    task automatic step();
        exp_t       e;
        logic [3:0] expFree;
        logic [3:0] expSel;
        logic       prevFree;
        @(posedge clk);
        #1;
        prevFree = freeNext;
        drv      = '0;
        freeNext = 1'b0;
        expFree  = '0;
        if (prevFree && outstanding) begin
            expFree     = grantMask;
            outstanding = 1'b0;
        end
        vectors++;
        if (freeV !== expFree) begin
            miscompares++;
            $display("FAIL free_pulse: o_free=%b expected %b at %0t", freeV, expFree, $time);
        end
        if (freeV != 4'b0) freeSeen++;
        if (cd > 0) begin
            cd--;
            if (cd == 0) freeNext = 1'b1;
        end
        if (driveNext === 1'b1) begin
            drvSeen++;
            vectors++;
            if (outstanding || grantQ.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_drive: select=%b data=%h, expected no drive at %0t", sel, dataNext, $time);
            end else begin
                e = grantQ.pop_front();
                expSel = 4'b0001 << e.port;
                if (sel !== expSel || dataNext !== e.data) begin
                    miscompares++;
                    $display("FAIL grant: select=%b data=%h, expected select=%b data=%h", sel, dataNext, expSel, e.data);
                end
                outstanding = 1'b1;
                grantMask   = expSel;
                if (autoDelay > 0) cd = autoDelay;
            end
        end
        expSel = outstanding ? grantMask : 4'b0;
        vectors++;
        if (sel !== expSel) begin
            miscompares++;
            $display("FAIL select_hold: select=%b expected %b at %0t", sel, expSel, $time);
        end
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n;
        n = 0;
        while ((grantQ.size() != 0 || outstanding || cd != 0 || freeNext) && n < budget) begin
            step();
            n++;
        end
        vectors++;
        if (grantQ.size() != 0 || outstanding) begin
            miscompares++;
            $display("FAIL %s_timeout: %0d grants still queued, outstanding=%b after %0d cycles, expected none",
                     name, grantQ.size(), outstanding, budget);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        grantQ.delete();
        outstanding = 1'b0;
        cd = 0;
        autoDelay = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step();
        vectors++;
        if (driveNext !== 1'b0 || sel !== 4'b0 || dataNext !== '0 || freeV !== 4'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: drive=%b sel=%b data=%h free=%b ovf=%b, expected all zero",
                     driveNext, sel, dataNext, freeV, overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        step();
        drv[2] = 1'b1;
        dat[2] = 32'hA5A5_0002;
        expectGrant(2'd2, 32'hA5A5_0002);
        step();
        vectors++;
        if (driveNext !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early: o_driveNext=%b one cycle after drive, expected 0", driveNext);
        end
        step();
        vectors++;
        if (driveNext !== 1'b1) begin
            miscompares++;
            $display("FAIL single_latency: o_driveNext=%b two cycles after drive, expected 1", driveNext);
        end
        step();
        step();
        vectors++;
        if (driveNext !== 1'b0 || sel !== 4'b0100 || dataNext !== 32'hA5A5_0002) begin
            miscompares++;
            $display("FAIL single_wait: drive=%b sel=%b data=%h, expected 0 0100 a5a50002", driveNext, sel, dataNext);
        end
        step();
        freeNext = 1'b1;
        step();
        vectors++;
        if (freeV !== 4'b0100 || sel !== 4'b0) begin
            miscompares++;
            $display("FAIL single_free: free=%b sel=%b, expected 0100 0000", freeV, sel);
        end
        step();
        vectors++;
        if (freeV !== 4'b0) begin
            miscompares++;
            $display("FAIL single_free_width: free=%b, expected 0000", freeV);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int base;
        doReset();
        autoDelay = 3;
        base = drvSeen;
        dat[0] = 32'h0000_1000;
        dat[1] = 32'h0000_1001;
        dat[3] = 32'h0000_1003;
        drv = 4'b1011;
        expectGrant(2'd0, 32'h0000_1000);
        expectGrant(2'd1, 32'h0000_1001);
`ifndef CMERGE_FIXED_PRIO_EN
        expectGrant(2'd3, 32'h0000_1003);
`endif
        n = 0;
        do begin
            step();
            n++;
        end while (freeV[0] !== 1'b1 && n < 40);
        vectors++;
        if (freeV[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rr_first_free: no o_free0 within %0d cycles, expected one", n);
        end
        drv[0] = 1'b1;
        dat[0] = 32'h0000_2000;
        expectGrant(2'd0, 32'h0000_2000);
`ifdef CMERGE_FIXED_PRIO_EN
        expectGrant(2'd3, 32'h0000_1003);
`endif
        waitIdle(100, "rr");
        vectors++;
        if (drvSeen - base != 4) begin
            miscompares++;
            $display("FAIL rr_count: %0d downstream drives, expected 4", drvSeen - base);
        end
    endtask

    task automatic test_overflow();
        int fbase;
        doReset();
        autoDelay = 3;
        fbase = freeSeen;
        drv[0] = 1'b1;
        dat[0] = 32'h0000_0A00;
        expectGrant(2'd0, 32'h0000_0A00);
        step();
        drv[1] = 1'b1;
        dat[1] = 32'h1111_0001;
        expectGrant(2'd1, 32'h1111_0001);
        step();
        drv[1] = 1'b1;
        dat[1] = 32'h2222_0002;
        step();
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: o_overflow=%b after double drive, expected 1", overflow);
        end
        waitIdle(60, "ovf");
        repeat (6) step();
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_sticky: o_overflow=%b, expected 1", overflow);
        end
        vectors++;
        if (freeSeen - fbase != 2) begin
            miscompares++;
            $display("FAIL overflow_frees: %0d free pulses, expected 2 (one for port 0, one for port 1)", freeSeen - fbase);
        end
        doReset();
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear: o_overflow=%b after reset, expected 0", overflow);
        end
    endtask

    task automatic test_same_cycle();
        doReset();
        drv[0] = 1'b1;
        dat[0] = 32'h0000_0AAA;
        expectGrant(2'd0, 32'h0000_0AAA);
        step();
        drv[2] = 1'b1;
        drv[3] = 1'b1;
        dat[2] = 32'h0000_0C02;
        dat[3] = 32'h0000_0C03;
        step();
        step();
        step();
        freeNext = 1'b1;
        drv[0] = 1'b1;
        dat[0] = 32'h0000_0BEE;
        autoDelay = 3;
`ifdef CMERGE_FIXED_PRIO_EN
        expectGrant(2'd0, 32'h0000_0BEE);
        expectGrant(2'd2, 32'h0000_0C02);
        expectGrant(2'd3, 32'h0000_0C03);
`else
        expectGrant(2'd2, 32'h0000_0C02);
        expectGrant(2'd3, 32'h0000_0C03);
        expectGrant(2'd0, 32'h0000_0BEE);
`endif
        step();
        vectors++;
        if (freeV !== 4'b0001) begin
            miscompares++;
            $display("FAIL same_cycle_free: free=%b, expected 0001", freeV);
        end
        waitIdle(80, "same_cycle");
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL same_cycle_ovf: o_overflow=%b, expected 0", overflow);
        end
    endtask

    task automatic test_spurious();
        doReset();
        step();
        freeNext = 1'b1;
        step();
        step();
        vectors++;
        if (freeV !== 4'b0 || sel !== 4'b0 || driveNext !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_free: free=%b sel=%b drive=%b, expected all zero", freeV, sel, driveNext);
        end
        drv[3] = 1'b1;
        dat[3] = 32'h3333_0003;
        expectGrant(2'd3, 32'h3333_0003);
        autoDelay = 3;
        step();
        vectors++;
        if (driveNext !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_early: o_driveNext=%b, expected 0", driveNext);
        end
        step();
        vectors++;
        if (driveNext !== 1'b1) begin
            miscompares++;
            $display("FAIL spurious_latency: o_driveNext=%b two cycles after drive, expected 1", driveNext);
        end
        waitIdle(40, "spurious");
    endtask

    task automatic test_reset_mid();
        int dbase;
        int fbase;
        doReset();
        drv = 4'b0110;
        dat[1] = 32'h4444_0001;
        dat[2] = 32'h4444_0002;
        expectGrant(2'd1, 32'h4444_0001);
        step();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (driveNext !== 1'b0 || sel !== 4'b0 || dataNext !== '0 || freeV !== 4'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: drive=%b sel=%b data=%h free=%b ovf=%b, expected all zero",
                     driveNext, sel, dataNext, freeV, overflow);
        end
        grantQ.delete();
        outstanding = 1'b0;
        step();
        step();
        rst = 1'b0;
        dbase = drvSeen;
        fbase = freeSeen;
        repeat (20) step();
        vectors++;
        if (drvSeen != dbase || freeSeen != fbase) begin
            miscompares++;
            $display("FAIL reset_drop: %0d drives %0d frees after reset, expected 0 0", drvSeen - dbase, freeSeen - fbase);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dat[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_same_cycle();
        test_spurious();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end
endmodule
